// File: rtl/ifu_fetch_queue.sv
// Instruction fetch unit: owns the fetch PC, reads the IM combinationally and
// buffers {pc, instr, adel} entries so decode can stall while fetch continues.
module ifu_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          IM_AW    = 12,
    parameter int          QDEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall,
    input  logic                        redirect,
    input  logic [31:0]                 redirect_pc,
    output logic [IM_AW-1:0]            im_addr,
    input  logic [31:0]                 im_rdata,
    output logic                        out_valid,
    output logic [31:0]                 out_instr,
    output logic [31:0]                 out_pc,
    output logic                        out_adel,
    output logic [$clog2(QDEPTH):0]     count
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(QDEPTH);
    // One past the last legal byte address; 33 bits so a window ending at 4 GiB cannot wrap.
    localparam logic [32:0] WIN_END = {1'b0, RESET_PC} + (33'd4 << IM_AW);

    logic [31:0]   pc;
    logic          halted;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] occ;

    logic [31:0]   q_pc    [QDEPTH];
    logic [31:0]   q_instr [QDEPTH];
    logic          q_adel  [QDEPTH];

    logic bad;
    logic push;
    logic pop;

    // Handshake: out_valid presents the head entry; it is consumed on every
    // cycle where out_valid is high and stall is low (unless redirect is high).
    assign out_valid = (occ != '0);
    assign pop       = out_valid & ~stall & ~redirect;
    assign push      = ~redirect & ~halted & ((occ < FULL) | pop);

    assign bad = (pc[1:0] != 2'b00)
               | (pc < RESET_PC)
               | ({1'b0, pc} >= WIN_END);

    assign im_addr = pc[IM_AW+1:2];
    assign count   = occ;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_PC;
            halted <= 1'b0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else if (redirect) begin
            pc     <= redirect_pc;
            halted <= 1'b0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                // A faulting address is queued once, then fetch parks on it.
                if (bad) begin
                    halted <= 1'b1;
                end else begin
                    pc <= pc + 32'd4;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            q_pc[wr_ptr]    <= pc;
            q_instr[wr_ptr] <= bad ? 32'h0 : im_rdata;
            q_adel[wr_ptr]  <= bad;
        end
    end

    always_comb begin
        out_instr = 32'h0;
        out_pc    = 32'h0;
        out_adel  = 1'b0;
        if (out_valid) begin
            out_instr = q_instr[rd_ptr];
            out_pc    = q_pc[rd_ptr];
            out_adel  = q_adel[rd_ptr];
        end
    end

endmodule
